// File: rtl/control_unit.sv
`default_nettype none
//============================================================================
// Module   : control_unit
// Brief    : Multicycle MIPS-subset control FSM (fetch/decode/execute/wb/exc)
// Revision : 1.0 - initial release
//============================================================================
module control_unit #(
  parameter logic [3:0] EXC_OPCODE = 4'd0,
  parameter logic [3:0] EXC_OVF    = 4'd1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OPCODE,
  input  logic [5:0] FUNCT,
  input  logic       Overflow,
  input  logic       Zero,
  output logic       PCwrite,
  output logic       MemWrite,
  output logic       MemRead,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemToReg,
  output logic       RegDest,
  output logic       AluSrcA,
  output logic       EPCWrite,
  output logic       IorD,
  output logic       ExceptionOcurred,
  output logic [2:0] ShiftControl,
  output logic [2:0] ALUControl,
  output logic [3:0] AluSrcB,
  output logic [3:0] PCSource,
  output logic [3:0] WriteSrc,
  output logic [3:0] Exception,
  output logic [4:0] state
);

  typedef enum logic [4:0] {
    ST_RESET   = 5'd0,  ST_FETCH  = 5'd1,  ST_MEMWAIT = 5'd2,  ST_LOAD_IR = 5'd3,
    ST_DECODE  = 5'd4,  ST_EXEC_R = 5'd5,  ST_WB_R    = 5'd6,  ST_EXEC_I  = 5'd7,
    ST_WB_I    = 5'd8,  ST_SH_LOAD = 5'd9, ST_SH_OP   = 5'd10, ST_SH_WB   = 5'd11,
    ST_ADDR    = 5'd12, ST_LW_RD  = 5'd13, ST_LW_WAIT = 5'd14, ST_LW_MDR  = 5'd15,
    ST_LW_WB   = 5'd16, ST_SW_WR  = 5'd17, ST_BRANCH  = 5'd18, ST_JUMP    = 5'd19,
    ST_EXC1    = 5'd20, ST_EXC2   = 5'd21, ST_EXC3    = 5'd22
  } state_t;

  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_ADDI  = 6'h08;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2B;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_BNE   = 6'h05;
  localparam logic [5:0] c_OP_J     = 6'h02;
  localparam logic [5:0] c_FN_ADD   = 6'h20;
  localparam logic [5:0] c_FN_SUB   = 6'h22;
  localparam logic [5:0] c_FN_AND   = 6'h24;
  localparam logic [5:0] c_FN_SLL   = 6'h00;
  localparam logic [5:0] c_FN_SRL   = 6'h02;
  localparam logic [2:0] c_ALU_ADD  = 3'b001;
  localparam logic [2:0] c_ALU_SUB  = 3'b010;
  localparam logic [2:0] c_ALU_AND  = 3'b011;

  state_t     r_state, w_next;
  logic [3:0] r_cause, w_cause_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RESET;
      r_cause <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cause <= w_cause_next;
    end
  end

  // Cause is captured only on the transition into EXC1 and held otherwise.
  always_comb begin
    w_next       = ST_FETCH;
    w_cause_next = r_cause;
    case (r_state)
      ST_RESET:   w_next = ST_FETCH;
      ST_FETCH:   w_next = ST_MEMWAIT;
      ST_MEMWAIT: w_next = ST_LOAD_IR;
      ST_LOAD_IR: w_next = ST_DECODE;
      ST_DECODE: begin
        case (OPCODE)
          c_OP_RTYPE: begin
            if (FUNCT == c_FN_ADD || FUNCT == c_FN_SUB || FUNCT == c_FN_AND) begin
              w_next = ST_EXEC_R;
            end else if (FUNCT == c_FN_SLL || FUNCT == c_FN_SRL) begin
              w_next = ST_SH_LOAD;
            end else begin
              w_next       = ST_EXC1;
              w_cause_next = EXC_OPCODE;
            end
          end
          c_OP_ADDI:          w_next = ST_EXEC_I;
          c_OP_LW, c_OP_SW:   w_next = ST_ADDR;
          c_OP_BEQ, c_OP_BNE: w_next = ST_BRANCH;
          c_OP_J:             w_next = ST_JUMP;
          default: begin
            w_next       = ST_EXC1;
            w_cause_next = EXC_OPCODE;
          end
        endcase
      end
      ST_EXEC_R: begin
        if (Overflow && FUNCT != c_FN_AND) begin
          w_next       = ST_EXC1;
          w_cause_next = EXC_OVF;
        end else begin
          w_next = ST_WB_R;
        end
      end
      ST_EXEC_I: begin
        if (Overflow) begin
          w_next       = ST_EXC1;
          w_cause_next = EXC_OVF;
        end else begin
          w_next = ST_WB_I;
        end
      end
      ST_SH_LOAD: w_next = ST_SH_OP;
      ST_SH_OP:   w_next = ST_SH_WB;
      ST_ADDR:    w_next = (OPCODE == c_OP_LW) ? ST_LW_RD : ST_SW_WR;
      ST_LW_RD:   w_next = ST_LW_WAIT;
      ST_LW_WAIT: w_next = ST_LW_MDR;
      ST_LW_MDR:  w_next = ST_LW_WB;
      ST_EXC1:    w_next = ST_EXC2;
      ST_EXC2:    w_next = ST_EXC3;
      default:    w_next = ST_FETCH;
    endcase
  end

  always_comb begin
    PCwrite          = 1'b0;
    MemWrite         = 1'b0;
    MemRead          = 1'b0;
    IRWrite          = 1'b0;
    RegWrite         = 1'b0;
    MemToReg         = 1'b0;
    RegDest          = 1'b0;
    AluSrcA          = 1'b0;
    EPCWrite         = 1'b0;
    IorD             = 1'b0;
    ExceptionOcurred = 1'b0;
    ShiftControl     = 3'b000;
    ALUControl       = 3'b000;
    AluSrcB          = 4'd0;
    PCSource         = 4'd0;
    WriteSrc         = 4'd0;
    Exception        = 4'd0;
    case (r_state)
      ST_FETCH: begin
        AluSrcB    = 4'd1;
        ALUControl = c_ALU_ADD;
        PCwrite    = 1'b1;
      end
      ST_LOAD_IR: IRWrite = 1'b1;
      ST_DECODE: begin
        AluSrcB    = 4'd3;
        ALUControl = c_ALU_ADD;
      end
      ST_EXEC_R: begin
        AluSrcA = 1'b1;
        case (FUNCT)
          c_FN_SUB: ALUControl = c_ALU_SUB;
          c_FN_AND: ALUControl = c_ALU_AND;
          default:  ALUControl = c_ALU_ADD;
        endcase
      end
      ST_WB_R: begin
        RegWrite = 1'b1;
        RegDest  = 1'b1;
      end
      ST_EXEC_I, ST_ADDR: begin
        AluSrcA    = 1'b1;
        AluSrcB    = 4'd2;
        ALUControl = c_ALU_ADD;
      end
      ST_WB_I:    RegWrite = 1'b1;
      ST_SH_LOAD: ShiftControl = 3'b001;
      ST_SH_OP:   ShiftControl = (FUNCT == c_FN_SRL) ? 3'b011 : 3'b010;
      ST_SH_WB: begin
        RegWrite = 1'b1;
        RegDest  = 1'b1;
        WriteSrc = 4'd3;
      end
      ST_LW_RD, ST_LW_WAIT: IorD = 1'b1;
      ST_LW_MDR: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      ST_LW_WB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      ST_SW_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      ST_BRANCH: begin
        AluSrcA    = 1'b1;
        ALUControl = c_ALU_SUB;
        PCSource   = 4'd1;
        PCwrite    = (OPCODE == c_OP_BEQ) ? Zero : !Zero;
      end
      ST_JUMP: begin
        PCSource = 4'd2;
        PCwrite  = 1'b1;
      end
      // PC-4 into ALUout so EPC records the faulting instruction.
      ST_EXC1: begin
        AluSrcB    = 4'd1;
        ALUControl = c_ALU_SUB;
      end
      ST_EXC2: EPCWrite = 1'b1;
      ST_EXC3: begin
        ExceptionOcurred = 1'b1;
        Exception        = r_cause;
        PCwrite          = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
//============================================================================
// Module   : tb_control_unit
// Brief    : Scoreboard bench for control_unit state sequences and controls
// Revision : 1.0 - initial release
//============================================================================
module tb_control_unit;

  localparam logic [4:0] S_RESET = 5'd0,   S_FETCH = 5'd1,   S_MEMWAIT = 5'd2,  S_LOAD_IR = 5'd3;
  localparam logic [4:0] S_DECODE = 5'd4,  S_EXEC_R = 5'd5,  S_WB_R = 5'd6,     S_EXEC_I = 5'd7;
  localparam logic [4:0] S_WB_I = 5'd8,    S_SH_LOAD = 5'd9, S_SH_OP = 5'd10,   S_SH_WB = 5'd11;
  localparam logic [4:0] S_ADDR = 5'd12,   S_LW_RD = 5'd13,  S_LW_WAIT = 5'd14, S_LW_MDR = 5'd15;
  localparam logic [4:0] S_LW_WB = 5'd16,  S_SW_WR = 5'd17,  S_BRANCH = 5'd18,  S_JUMP = 5'd19;
  localparam logic [4:0] S_EXC1 = 5'd20,   S_EXC2 = 5'd21,   S_EXC3 = 5'd22;

  typedef struct packed {
    logic pcw, mw, mr, irw, rw, m2r, rd, asa, epcw, iord, exo;
    logic [2:0] sh, alu;
    logic [3:0] asb, pcs, ws, exc;
  } ctl_t;

  typedef struct packed {
    logic [4:0] st;
    ctl_t       ctl;
  } exp_t;

  typedef struct {
    string       name;
    logic [5:0]  op, fn;
    logic        ovf, z;
    logic [3:0]  cause;
    int          n;
    logic [24:0] tail;
  } case_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op = 6'h00, fn = 6'h00;
  logic       ovf = 1'b0, zero = 1'b0;
  logic       PCwrite, MemWrite, MemRead, IRWrite, RegWrite, MemToReg, RegDest, AluSrcA;
  logic       EPCWrite, IorD, ExceptionOcurred;
  logic [2:0] ShiftControl, ALUControl;
  logic [3:0] AluSrcB, PCSource, WriteSrc, Exception;
  logic [4:0] st;
  ctl_t       obs;
  logic [3:0] exp_cause = 4'd0;
  exp_t       sb[$];
  int         checks = 0;
  int         passed = 0;

  control_unit #(.EXC_OPCODE(4'd0), .EXC_OVF(4'd1)) dut (
    .clk(clk), .reset(reset), .OPCODE(op), .FUNCT(fn), .Overflow(ovf), .Zero(zero),
    .PCwrite(PCwrite), .MemWrite(MemWrite), .MemRead(MemRead), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .MemToReg(MemToReg), .RegDest(RegDest), .AluSrcA(AluSrcA),
    .EPCWrite(EPCWrite), .IorD(IorD), .ExceptionOcurred(ExceptionOcurred),
    .ShiftControl(ShiftControl), .ALUControl(ALUControl), .AluSrcB(AluSrcB),
    .PCSource(PCSource), .WriteSrc(WriteSrc), .Exception(Exception), .state(st)
  );

  always #5 clk = ~clk;

  assign obs = {PCwrite, MemWrite, MemRead, IRWrite, RegWrite, MemToReg, RegDest, AluSrcA,
                EPCWrite, IorD, ExceptionOcurred, ShiftControl, ALUControl,
                AluSrcB, PCSource, WriteSrc, Exception};

  // Expected control pattern for one state, taken from the per-state output table.
  function automatic ctl_t exp_ctl(input logic [4:0] s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:   begin c.asb = 4'd1; c.alu = 3'b001; c.pcw = 1'b1; end
      S_LOAD_IR: c.irw = 1'b1;
      S_DECODE:  begin c.asb = 4'd3; c.alu = 3'b001; end
      S_EXEC_R:  begin
        c.asa = 1'b1;
        c.alu = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : 3'b011;
      end
      S_WB_R:    begin c.rw = 1'b1; c.rd = 1'b1; end
      S_EXEC_I:  begin c.asa = 1'b1; c.asb = 4'd2; c.alu = 3'b001; end
      S_WB_I:    c.rw = 1'b1;
      S_SH_LOAD: c.sh = 3'b001;
      S_SH_OP:   c.sh = (fn == 6'h00) ? 3'b010 : 3'b011;
      S_SH_WB:   begin c.rw = 1'b1; c.rd = 1'b1; c.ws = 4'd3; end
      S_ADDR:    begin c.asa = 1'b1; c.asb = 4'd2; c.alu = 3'b001; end
      S_LW_RD:   c.iord = 1'b1;
      S_LW_WAIT: c.iord = 1'b1;
      S_LW_MDR:  begin c.iord = 1'b1; c.mr = 1'b1; end
      S_LW_WB:   begin c.rw = 1'b1; c.m2r = 1'b1; end
      S_SW_WR:   begin c.iord = 1'b1; c.mw = 1'b1; end
      S_BRANCH:  begin
        c.asa = 1'b1; c.alu = 3'b010; c.pcs = 4'd1;
        c.pcw = (op == 6'h04) ? zero : ~zero;
      end
      S_JUMP:    begin c.pcs = 4'd2; c.pcw = 1'b1; end
      S_EXC1:    begin c.asb = 4'd1; c.alu = 3'b010; end
      S_EXC2:    c.epcw = 1'b1;
      S_EXC3:    begin c.exo = 1'b1; c.exc = exp_cause; c.pcw = 1'b1; end
      default:   c = '0;
    endcase
    return c;
  endfunction

  function automatic case_t mk(input string nm, input logic [5:0] o, input logic [5:0] f,
                               input logic v, input logic zz, input logic [3:0] ca,
                               input int n, input logic [24:0] tail);
    case_t c;
    c.name = nm; c.op = o; c.fn = f; c.ovf = v; c.z = zz; c.cause = ca; c.n = n; c.tail = tail;
    return c;
  endfunction

  task automatic push(input logic [4:0] s);
    sb.push_back({s, exp_ctl(s)});
  endtask

  task automatic push_instr(input case_t c);
    op = c.op; fn = c.fn; ovf = c.ovf; zero = c.z; exp_cause = c.cause;
    push(S_FETCH); push(S_MEMWAIT); push(S_LOAD_IR); push(S_DECODE);
    for (int j = 0; j < c.n; j++) push(c.tail[24-5*j -: 5]);
  endtask

  task automatic test_reset;
    exp_t e;
    reset = 1'b0; op = 6'h23; fn = 6'h20; ovf = 1'b1; zero = 1'b1;
    #2;
    push(S_RESET); push(S_RESET);
    for (int j = 0; sb.size() > 0; j++) begin
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (st !== e.st || obs !== e.ctl)
        $display("FAIL reset cycle %0d: got state=%0d ctl=%h, expected state=%0d ctl=%h",
                 j, st, obs, e.st, e.ctl);
      else passed++;
    end
    #1 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu;
    exp_t  e;
    case_t cs [9];
    cs[0] = mk("add",      6'h00, 6'h20, 1'b0, 1'b0, 4'd0, 2, {S_EXEC_R, S_WB_R, 15'd0});
    cs[1] = mk("sub",      6'h00, 6'h22, 1'b0, 1'b1, 4'd0, 2, {S_EXEC_R, S_WB_R, 15'd0});
    cs[2] = mk("and_ovf",  6'h00, 6'h24, 1'b1, 1'b0, 4'd0, 2, {S_EXEC_R, S_WB_R, 15'd0});
    cs[3] = mk("add_ovf",  6'h00, 6'h20, 1'b1, 1'b0, 4'd1, 4, {S_EXEC_R, S_EXC1, S_EXC2, S_EXC3, 5'd0});
    cs[4] = mk("bad_op",   6'h3F, 6'h20, 1'b1, 1'b0, 4'd0, 3, {S_EXC1, S_EXC2, S_EXC3, 10'd0});
    cs[5] = mk("addi",     6'h08, 6'h15, 1'b0, 1'b0, 4'd0, 2, {S_EXEC_I, S_WB_I, 15'd0});
    cs[6] = mk("addi_ovf", 6'h08, 6'h15, 1'b1, 1'b0, 4'd1, 4, {S_EXEC_I, S_EXC1, S_EXC2, S_EXC3, 5'd0});
    cs[7] = mk("bad_fn",   6'h00, 6'h21, 1'b0, 1'b0, 4'd0, 3, {S_EXC1, S_EXC2, S_EXC3, 10'd0});
    cs[8] = mk("sub_ovf",  6'h00, 6'h22, 1'b1, 1'b0, 4'd1, 4, {S_EXEC_R, S_EXC1, S_EXC2, S_EXC3, 5'd0});
    foreach (cs[k]) begin
      push_instr(cs[k]);
      for (int j = 0; sb.size() > 0; j++) begin
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (st !== e.st || obs !== e.ctl)
          $display("FAIL %s cycle %0d: got state=%0d ctl=%h, expected state=%0d ctl=%h",
                   cs[k].name, j, st, obs, e.st, e.ctl);
        else passed++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_shift_mem;
    exp_t  e;
    case_t cs [4];
    cs[0] = mk("sll", 6'h00, 6'h00, 1'b1, 1'b0, 4'd0, 3, {S_SH_LOAD, S_SH_OP, S_SH_WB, 10'd0});
    cs[1] = mk("srl", 6'h00, 6'h02, 1'b0, 1'b1, 4'd0, 3, {S_SH_LOAD, S_SH_OP, S_SH_WB, 10'd0});
    cs[2] = mk("lw",  6'h23, 6'h00, 1'b1, 1'b1, 4'd0, 5, {S_ADDR, S_LW_RD, S_LW_WAIT, S_LW_MDR, S_LW_WB});
    cs[3] = mk("sw",  6'h2B, 6'h00, 1'b1, 1'b0, 4'd0, 2, {S_ADDR, S_SW_WR, 15'd0});
    foreach (cs[k]) begin
      push_instr(cs[k]);
      for (int j = 0; sb.size() > 0; j++) begin
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (st !== e.st || obs !== e.ctl)
          $display("FAIL %s cycle %0d: got state=%0d ctl=%h, expected state=%0d ctl=%h",
                   cs[k].name, j, st, obs, e.st, e.ctl);
        else passed++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_jump;
    exp_t  e;
    case_t cs [5];
    cs[0] = mk("beq_taken",  6'h04, 6'h00, 1'b1, 1'b1, 4'd0, 1, {S_BRANCH, 20'd0});
    cs[1] = mk("beq_not",    6'h04, 6'h00, 1'b0, 1'b0, 4'd0, 1, {S_BRANCH, 20'd0});
    cs[2] = mk("bne_taken",  6'h05, 6'h00, 1'b0, 1'b0, 4'd0, 1, {S_BRANCH, 20'd0});
    cs[3] = mk("bne_not",    6'h05, 6'h00, 1'b1, 1'b1, 4'd0, 1, {S_BRANCH, 20'd0});
    cs[4] = mk("jump",       6'h02, 6'h3F, 1'b1, 1'b1, 4'd0, 1, {S_JUMP, 20'd0});
    foreach (cs[k]) begin
      push_instr(cs[k]);
      for (int j = 0; sb.size() > 0; j++) begin
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (st !== e.st || obs !== e.ctl)
          $display("FAIL %s cycle %0d: got state=%0d ctl=%h, expected state=%0d ctl=%h",
                   cs[k].name, j, st, obs, e.st, e.ctl);
        else passed++;
      end
      @(posedge clk); #1;
    end
  endtask

  // Reset is pulled in LW_WAIT, between clock edges, then released; a jump follows.
  task automatic test_reset_mid;
    exp_t  e;
    string ph [4] = '{"pre_reset", "async_drop", "held_low", "released"};
    push_instr(mk("lw_part", 6'h23, 6'h00, 1'b0, 1'b0, 4'd0, 2, {S_ADDR, S_LW_RD, 15'd0}));
    for (int j = 0; sb.size() > 0; j++) begin
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (st !== e.st || obs !== e.ctl)
        $display("FAIL lw_part cycle %0d: got state=%0d ctl=%h, expected state=%0d ctl=%h",
                 j, st, obs, e.st, e.ctl);
      else passed++;
    end
    @(posedge clk); #1;
    for (int p = 0; p < 4; p++) begin
      case (p)
        0: push(S_LW_WAIT);
        1: begin reset = 1'b0; #1; push(S_RESET); end
        2: begin @(negedge clk); push(S_RESET); end
        default: begin
          @(posedge clk); #1; reset = 1'b1; push(S_RESET);
          @(negedge clk);
        end
      endcase
      e = sb.pop_front();
      checks++;
      if (st !== e.st || obs !== e.ctl)
        $display("FAIL %s: got state=%0d ctl=%h, expected state=%0d ctl=%h",
                 ph[p], st, obs, e.st, e.ctl);
      else passed++;
    end
    @(posedge clk); #1;
    push_instr(mk("jump_after_reset", 6'h02, 6'h00, 1'b0, 1'b0, 4'd0, 1, {S_JUMP, 20'd0}));
    for (int j = 0; sb.size() > 0; j++) begin
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (st !== e.st || obs !== e.ctl)
        $display("FAIL jump_after_reset cycle %0d: got state=%0d ctl=%h, expected state=%0d ctl=%h",
                 j, st, obs, e.st, e.ctl);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_shift_mem();
    test_branch_jump();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/control_unit.md
# control_unit

Multicycle FSM driving every control line of the CPU datapath: PC, memory, IR, register bank, ALU, shift register and EPC. It sits opposite the datapath on the control interface. It consumes the opcode, funct and ALU flags, and issues the select/enable pattern for each cycle of fetch, decode, execute, writeback and exception entry. It covers a scoped MIPS subset; HI/LO, div and mult are out of scope for this block.

## Interface
Parameters:
- EXC_OPCODE, 0, Exception select code for invalid opcode/funct
- EXC_OVF, 1, Exception select code for arithmetic overflow

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- OPCODE  in  6  IR[31:26]
- FUNCT  in  6  IR[5:0]
- Overflow  in  1  ALU overflow, combinational
- Zero  in  1  ALU zero flag, combinational
- PCwrite, MemWrite, MemRead, IRWrite, RegWrite, MemToReg, RegDest, AluSrcA, EPCWrite, IorD, ExceptionOcurred  out  1 each  datapath enables/selects
- ShiftControl  out  3  000 hold, 001 load B, 010 shift left logical, 011 shift right logical
- ALUControl  out  3  001 add, 010 sub, 011 and
- AluSrcB  out  4  0 B, 1 constant 4, 2 sign-extended imm, 3 sign-extended imm<<2
- PCSource  out  4  0 ALUResult, 1 ALUout, 2 jump target, 3 EPC
- WriteSrc  out  4  0 ALUout, 3 Shiftout
- Exception  out  4  exception vector select
- state  out  5  current state, debug

## Operation
- Moore decode of `state`. The single exception is PCwrite in BRANCH, which is also a function of Zero.
- Every output is 0 in every state unless listed for that state.
- RegDest: 0 selects RT, 1 selects RD.
- AluSrcA: 0 selects PC, 1 selects A.
- Common path, every instruction:
  - FETCH: IorD=0, AluSrcA=0, AluSrcB=1, ALUControl=add, PCSource=0, PCwrite=1.
  - MEMWAIT: no outputs asserted.
  - LOAD_IR: IRWrite=1.
  - DECODE: AluSrcA=0, AluSrcB=3, ALUControl=add. Branch target lands in ALUout.
- Dispatch from DECODE:
  - OPCODE 0x00 with FUNCT 0x20/0x22/0x24: EXEC_R.
  - OPCODE 0x00 with FUNCT 0x00/0x02: SH_LOAD.
  - 0x08 (addi): EXEC_I.
  - 0x23 (lw) or 0x2B (sw): ADDR.
  - 0x04 or 0x05: BRANCH.
  - 0x02: JUMP.
  - Anything else: EXC1 with cause EXC_OPCODE.
- EXEC_R: AluSrcA=1, AluSrcB=0, ALUControl=add/sub/and per FUNCT.
  - Overflow=1 on add/sub goes to EXC1 with cause EXC_OVF.
  - Otherwise next state is WB_R.
- WB_R: RegWrite=1, RegDest=1, WriteSrc=0, MemToReg=0. Next: FETCH.
- EXEC_I: AluSrcA=1, AluSrcB=2, add.
  - Overflow goes to EXC1 with cause EXC_OVF.
  - Otherwise next state is WB_I.
- WB_I: RegWrite=1, RegDest=0, WriteSrc=0.
- SH_LOAD: ShiftControl=001.
- SH_OP: ShiftControl=010 (sll) or 011 (srl).
- SH_WB: RegWrite=1, RegDest=1, WriteSrc=3.
- ADDR: AluSrcA=1, AluSrcB=2, add.
  - lw goes to LW_RD.
  - sw goes to SW_WR.
- lw sequence:
  - LW_RD: IorD=1.
  - LW_WAIT: IorD=1.
  - LW_MDR: IorD=1, MemRead=1.
  - LW_WB: RegWrite=1, RegDest=0, MemToReg=1.
- SW_WR: IorD=1, MemWrite=1 for exactly one cycle.
- BRANCH: AluSrcA=1, AluSrcB=0, sub, PCSource=1.
  - PCwrite = Zero for beq (0x04).
  - PCwrite = !Zero for bne (0x05).
- JUMP: PCSource=2, PCwrite=1.
- Exception entry:
  - EXC1: AluSrcA=0, AluSrcB=1, sub. ALUout receives PC-4.
  - EXC2: EPCWrite=1.
  - EXC3: ExceptionOcurred=1, Exception=latched cause, PCwrite=1.
- The cause register is 4 bits. It is loaded on entry to EXC1 and held through EXC3.
- Every terminal state (WB_*, SH_WB, LW_WB, SW_WR, BRANCH, JUMP, EXC3) returns to FETCH.

## Timing
- reset low: state = RESET asynchronously, all outputs 0, cause = 0.
- First rising edge with reset high: RESET goes to FETCH.
- Total cycles per instruction, counting from FETCH:
  - branch / jump: 5
  - R-type ALU, addi, sw: 6
  - shift: 7
  - lw: 9
  - exception from DECODE: 7
  - exception from EXEC: 8
- Overflow and Zero are sampled only in their decision states (EXEC_R/EXEC_I and BRANCH); they are ignored elsewhere.
- Overflow on `and` is ignored.
- MemWrite, IRWrite, EPCWrite and RegWrite are single-cycle pulses; none is ever asserted in two consecutive cycles.
- reset asserted mid-instruction: all outputs drop to 0 immediately, with no partial writeback. Fetch restarts on the first edge after release.
- OPCODE/FUNCT are read only in DECODE and the states after it. The IR is stable from LOAD_IR+1 until the next LOAD_IR.

## Test plan
- Reset release, then OPCODE=0x00 FUNCT=0x20, Overflow=0 -> states RESET, FETCH, MEMWAIT, LOAD_IR, DECODE, EXEC_R, WB_R, FETCH. RegWrite=1 with RegDest=1 only in WB_R; PCwrite=1 only in FETCH.
- addi with Overflow=1 in EXEC_I -> EXC1, EXC2 (EPCWrite=1), EXC3 (ExceptionOcurred=1, Exception=1, PCwrite=1). RegWrite stays 0 throughout.
- OPCODE=0x3F -> DECODE goes to EXC1; Exception=0 in EXC3; 7 cycles total.
- lw (0x23) -> IorD=1 for 3 cycles, MemRead=1 in LW_MDR, MemToReg=1 and RegWrite=1 in LW_WB; 9 cycles. sw (0x2B) -> MemWrite=1 for exactly one cycle.
- beq with Zero=1 -> PCwrite=1, PCSource=1 in BRANCH. beq with Zero=0 -> PCwrite=0. bne with Zero=0 -> PCwrite=1. j -> PCSource=2.
- Assert reset during LW_WAIT -> all outputs 0 the same cycle; after release, the next states are RESET then FETCH.
